// File: rtl/pkt_pkg.sv
// Shared definitions for the packet width packer: control field width,
// lane-index sizing and FSM state encoding.
package pkt_pkg;

    localparam int CTL_W = 8;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_IN_PKT = 1'b1;

    function automatic int lane_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/pkt_sync_fifo.sv
// Show-ahead synchronous FIFO with up to two pushes per cycle (second entry
// lands behind the first) and an occupancy count.
module pkt_sync_fifo #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push_a,
    input  logic [W-1:0]         data_a,
    input  logic                 push_b,
    input  logic [W-1:0]         data_b,
    input  logic                 pop,
    output logic [W-1:0]         head,
    output logic [$clog2(D):0]   count
);
    localparam int AW = $clog2(D);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [D];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push_a) mem[wr_ptr] <= data_a;
        if (push_b) mem[wr_ptr + AW'(1)] <= data_b;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_a) + AW'(push_b);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + CW'(push_a) + CW'(push_b) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/pkt_width_packer.sv
// Packs a framed IN_W-bit beat stream into OUT_W-bit words (first beat in the
// MSBs) with byte count and sop/last/err flags, buffered by an output FIFO.
module pkt_width_packer
    import pkt_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 512,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               in_sop,
    input  logic               in_eop,
    input  logic [IN_W-1:0]    in_data,
    output logic               in_ready,
    output logic               out_wr,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic [CTL_W-1:0]   out_ctl,
    output logic               out_sop,
    output logic               out_last,
    output logic               out_err,
    output logic [CNT_W-1:0]   drop_cnt
);
    localparam int R   = OUT_W / IN_W;
    localparam int LW  = lane_w(R);
    localparam int BPL = IN_W / 8;
    localparam int FW  = OUT_W + CTL_W + 3;
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(R - 1);

    logic [0:0]       state, state_n;
    logic [LW-1:0]    lane, lane_n;
    logic [OUT_W-1:0] acc, acc_n;
    logic             first, first_n;
    logic             push_a, push_b, drop_inc;
    logic [FW-1:0]    entry_a, entry_b, fresh_entry, head;
    logic [OUT_W-1:0] fresh, merged;
    logic [CW-1:0]    fifo_count;
    logic             accept, fresh_done, need_two;

    // A beat that both starts and ends a packet can always be emitted on its own.
    assign fresh_done = in_eop || (R == 1);
    // A sop arriving mid-packet that also closes its packet pushes two words.
    assign need_two   = (state == ST_IN_PKT) && in_sop && fresh_done;
    assign in_ready   = reset && (fifo_count < CW'(DEPTH))
                        && !(need_two && (fifo_count > CW'(DEPTH - 2)));
    assign accept     = in_valid && in_ready;

    always_comb begin
        fresh = '0;
        fresh[OUT_W-1 -: IN_W] = in_data;
        merged = acc;
        for (int k = 0; k < R; k++) begin
            if (LW'(k) == lane) merged[OUT_W-1-k*IN_W -: IN_W] = in_data;
        end
        fresh_entry = {fresh, CTL_W'(BPL), 1'b1, in_eop, 1'b0};
    end

    always_comb begin
        state_n  = state;
        lane_n   = lane;
        acc_n    = acc;
        first_n  = first;
        push_a   = 1'b0;
        push_b   = 1'b0;
        entry_a  = '0;
        entry_b  = '0;
        drop_inc = 1'b0;
        if (accept) begin
            if (state == ST_IDLE && !in_sop) begin
                drop_inc = 1'b1;
            end else if (state == ST_IN_PKT && !in_sop) begin
                if (lane == LAST_LANE || in_eop) begin
                    push_a  = 1'b1;
                    entry_a = {merged, CTL_W'((int'(lane) + 1) * BPL), first, in_eop, 1'b0};
                    acc_n   = '0;
                    lane_n  = '0;
                    first_n = 1'b0;
                    if (in_eop) state_n = ST_IDLE;
                end else begin
                    acc_n  = merged;
                    lane_n = lane + 1'b1;
                end
            end else begin
                if (state == ST_IN_PKT) begin
                    push_a   = 1'b1;
                    entry_a  = {acc, CTL_W'(int'(lane) * BPL), first, 1'b1, 1'b1};
                    drop_inc = 1'b1;
                end
                if (fresh_done) begin
                    if (state == ST_IN_PKT) begin
                        push_b  = 1'b1;
                        entry_b = fresh_entry;
                    end else begin
                        push_a  = 1'b1;
                        entry_a = fresh_entry;
                    end
                    acc_n   = '0;
                    lane_n  = '0;
                    first_n = 1'b0;
                    state_n = in_eop ? ST_IDLE : ST_IN_PKT;
                end else begin
                    acc_n   = fresh;
                    lane_n  = LW'(1);
                    first_n = 1'b1;
                    state_n = ST_IN_PKT;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            lane     <= '0;
            acc      <= '0;
            first    <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state <= state_n;
            lane  <= lane_n;
            acc   <= acc_n;
            first <= first_n;
            if (drop_inc && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    pkt_sync_fifo #(.W(FW), .D(DEPTH)) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_a (push_a),
        .data_a (entry_a),
        .push_b (push_b),
        .data_b (entry_b),
        .pop    (out_wr && out_ready),
        .head   (head),
        .count  (fifo_count)
    );

    assign out_wr = reset && (fifo_count != '0);
    assign {out_data, out_ctl, out_sop, out_last, out_err} = head;

endmodule
